// File: rtl/ssb_capture_buffer.sv
// ssb_capture_buffer
//   Circular sample buffer that aligns NUM_CH parallel sample streams with a
//   late PSS peak-detect trigger. On a trigger it emits a gated burst of
//   CAPTURE_LEN samples starting L accepted samples before the trigger, where
//   L is lookback_i latched on the trigger cycle. The last burst sample
//   carries tlast.
//
//   Optional feature macro: SSB_CAPTURE_RETRIGGER_EN
//     undefined : a trigger during a burst is dropped (trigger_dropped_o pulse),
//                 truncated_o is constant 0.
//     defined   : a trigger during a burst (other than on its final sample)
//                 restarts the burst and pulses truncated_o.
//
//   Handshake: s_axis_in_tvalid marks an accepted input (no backpressure);
//   m_axis_out_tvalid marks a valid output word exactly one cycle after the
//   accepted input that produced it. There is no ready on either side.
module ssb_capture_buffer #(
    parameter int IN_DW       = 32,
    parameter int NUM_CH      = 1,
    parameter int DEPTH       = 64,
    parameter int CAPTURE_LEN = 1096,
    parameter int LB_W        = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_CH*IN_DW-1:0] s_axis_in_tdata,
    input  logic                    s_axis_in_tvalid,
    input  logic                    trigger_i,
    input  logic [LB_W-1:0]         lookback_i,
    output logic [NUM_CH*IN_DW-1:0] m_axis_out_tdata,
    output logic                    m_axis_out_tvalid,
    output logic                    m_axis_out_tlast,
    output logic                    busy_o,
    output logic                    trigger_dropped_o,
    output logic                    truncated_o
);

    localparam int DW = NUM_CH * IN_DW;
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(CAPTURE_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CAPTURE_LEN - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t          state_q;
    logic [LB_W-1:0] wp_q;
    logic [LB_W-1:0] lb_q;
    logic [FW-1:0]   fill_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   mem [DEPTH];

    logic            in_capture;
    logic            final_in;
    logic            start;
    logic            restart_cap;
    logic            restart;
    logic            drop;
    logic [LB_W-1:0] eff_lb;
    logic [CW-1:0]   eff_cnt;
    logic            active;
    logic            emit;
    logic            emit_last;
    logic [LB_W-1:0] rd_addr;
    logic [DW-1:0]   rd_word;

    // Decode this cycle's trigger, the effective lookback/count and the output word
    always_comb begin
        in_capture = (state_q == ST_CAPTURE);
        // The accepted input that closes the running burst.
        final_in   = in_capture && s_axis_in_tvalid && (cnt_q == LAST_CNT);
        start      = trigger_i && !in_capture;
`ifdef SSB_CAPTURE_RETRIGGER_EN
        restart_cap = trigger_i && in_capture && !final_in;
`else
        restart_cap = 1'b0;
`endif
        restart    = start || restart_cap;
        // A trigger on the final sample is always dropped; without the
        // retrigger feature any trigger during a burst is dropped.
        drop       = trigger_i && in_capture && !restart_cap;
        eff_lb     = restart ? lookback_i : lb_q;
        eff_cnt    = restart ? '0 : cnt_q;
        // A trigger in IDLE enters CAPTURE in the same cycle, so a coincident
        // valid input already becomes burst sample 0.
        active     = in_capture || start;
        emit       = s_axis_in_tvalid && active;
        emit_last  = emit && (eff_cnt == LAST_CNT);
        // Pointer subtraction wraps naturally modulo DEPTH.
        rd_addr    = wp_q - eff_lb;
        if (eff_lb == '0) begin
            rd_word = s_axis_in_tdata;
        end else if (fill_q < FW'(eff_lb)) begin
            rd_word = '0;
        end else begin
            rd_word = mem[rd_addr];
        end
    end

    // Sample RAM write port; contents intentionally survive reset
    always_ff @(posedge clk_i) begin
        if (s_axis_in_tvalid) begin
            mem[wp_q] <= s_axis_in_tdata;
        end
    end

    // Pointer, fill level, capture FSM and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q           <= ST_IDLE;
            wp_q              <= '0;
            lb_q              <= '0;
            fill_q            <= '0;
            cnt_q             <= '0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
            m_axis_out_tlast  <= 1'b0;
            trigger_dropped_o <= 1'b0;
        end else begin
            if (s_axis_in_tvalid) begin
                wp_q <= wp_q + LB_W'(1);
                if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + FW'(1);
                end
            end

            lb_q <= eff_lb;

            if (emit_last) begin
                cnt_q   <= '0;
                state_q <= ST_IDLE;
            end else if (emit) begin
                cnt_q   <= eff_cnt + CW'(1);
                state_q <= ST_CAPTURE;
            end else begin
                cnt_q   <= eff_cnt;
                state_q <= active ? ST_CAPTURE : ST_IDLE;
            end

            m_axis_out_tvalid <= emit;
            m_axis_out_tlast  <= emit_last;
            m_axis_out_tdata  <= emit ? rd_word : '0;
            trigger_dropped_o <= drop;
        end
    end

`ifdef SSB_CAPTURE_RETRIGGER_EN
    // One-cycle pulse when a running burst is cut short by a retrigger
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            truncated_o <= 1'b0;
        end else begin
            truncated_o <= restart_cap;
        end
    end
`else
    assign truncated_o = 1'b0;
`endif

    assign busy_o = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_ssb_capture_buffer.sv
// Directed bench for ssb_capture_buffer: a single-channel instance
// (DEPTH 64, CAPTURE_LEN 8) and a four-channel instance (DEPTH 8,
// CAPTURE_LEN 1) share clock and reset.
module tb_ssb_capture_buffer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic [31:0] a_d;
  logic        a_v;
  logic        a_t;
  logic [5:0]  a_lb;
  logic [31:0] a_out_d;
  logic        a_out_v, a_out_l, a_busy, a_drop, a_trunc;

  ssb_capture_buffer #(
    .IN_DW(32), .NUM_CH(1), .DEPTH(64), .CAPTURE_LEN(8)
  ) dut_a (
    .clk_i(clk), .reset_i(rst),
    .s_axis_in_tdata(a_d), .s_axis_in_tvalid(a_v),
    .trigger_i(a_t), .lookback_i(a_lb),
    .m_axis_out_tdata(a_out_d), .m_axis_out_tvalid(a_out_v),
    .m_axis_out_tlast(a_out_l), .busy_o(a_busy),
    .trigger_dropped_o(a_drop), .truncated_o(a_trunc)
  );

  // ---------------- instance B ----------------
  logic [63:0] b_d;
  logic        b_v;
  logic        b_t;
  logic [2:0]  b_lb;
  logic [63:0] b_out_d;
  logic        b_out_v, b_out_l, b_busy, b_drop, b_trunc;

  ssb_capture_buffer #(
    .IN_DW(16), .NUM_CH(4), .DEPTH(8), .CAPTURE_LEN(1)
  ) dut_b (
    .clk_i(clk), .reset_i(rst),
    .s_axis_in_tdata(b_d), .s_axis_in_tvalid(b_v),
    .trigger_i(b_t), .lookback_i(b_lb),
    .m_axis_out_tdata(b_out_d), .m_axis_out_tvalid(b_out_v),
    .m_axis_out_tlast(b_out_l), .busy_o(b_busy),
    .trigger_dropped_o(b_drop), .truncated_o(b_trunc)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int a_idx = 0;
  int b_idx = 0;
  int a_drop_n = 0, a_trunc_n = 0, b_drop_n = 0, b_trunc_n = 0;
  logic [32:0] exp_a_q[$];
  logic [64:0] exp_b_q[$];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] adat(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  function automatic logic [63:0] bdat(input int i);
    logic [63:0] r;
    for (int c = 0; c < 4; c++) r[c*16 +: 16] = 16'((c + 1) * 4096 + (i & 4095));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic a_step(input logic t, input logic [5:0] lb);
    @(negedge clk);
    a_v = 1'b1; a_d = adat(a_idx); a_t = t; a_lb = lb;
    a_idx++;
  endtask

  task automatic a_gap(input logic t, input logic [5:0] lb);
    @(negedge clk);
    a_v = 1'b0; a_d = 32'h5A5A_0000 | 32'(a_idx); a_t = t; a_lb = lb;
  endtask

  task automatic b_step(input logic t, input logic [2:0] lb);
    @(negedge clk);
    b_v = 1'b1; b_d = bdat(b_idx); b_t = t; b_lb = lb;
    b_idx++;
  endtask

  task automatic push_a(input logic last, input logic [31:0] val);
    exp_a_q.push_back({last, val});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_v = 1'b0; a_t = 1'b0; b_v = 1'b0; b_t = 1'b0;
    @(negedge clk);
    a_drop_n = 0; a_trunc_n = 0; b_drop_n = 0; b_trunc_n = 0;
    @(negedge clk);
    rst = 1'b0;
    a_idx = 0; b_idx = 0;
  endtask

  task automatic end_test_a(input string tag);
    repeat (3) a_gap(1'b0, 6'd0);
    check_eq({tag, "_pending"}, 128'(exp_a_q.size()), 128'd0);
    check_eq({tag, "_busy"}, 128'(a_busy), 128'd0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (a_drop) a_drop_n++;
    if (a_trunc) a_trunc_n++;
    if (a_out_v) begin
      if (exp_a_q.size() == 0) begin
        check_eq("a_extra_out", 128'(a_out_v), 128'd0);
      end else begin
        e = exp_a_q.pop_front();
        check_eq("a_data", 128'(a_out_d), 128'(e[31:0]));
        check_eq("a_last", 128'(a_out_l), 128'(e[32]));
      end
    end else if (a_out_l) begin
      check_eq("a_last_no_valid", 128'(a_out_l), 128'd0);
    end
  end

  always @(negedge clk) begin
    logic [64:0] e;
    if (b_drop) b_drop_n++;
    if (b_trunc) b_trunc_n++;
    if (b_out_v) begin
      if (exp_b_q.size() == 0) begin
        check_eq("b_extra_out", 128'(b_out_v), 128'd0);
      end else begin
        e = exp_b_q.pop_front();
        check_eq("b_data", 128'(b_out_d), 128'(e[63:0]));
        check_eq("b_last", 128'(b_out_l), 128'(e[64]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    a_v = 1'b0; a_d = '0; a_t = 1'b0; a_lb = '0;
    b_v = 1'b0; b_d = '0; b_t = 1'b0; b_lb = '0;

    // Reset state of both instances
    @(negedge clk);
    check_eq("rst_a_valid", 128'(a_out_v), 128'd0);
    check_eq("rst_a_data", 128'(a_out_d), 128'd0);
    check_eq("rst_a_last", 128'(a_out_l), 128'd0);
    check_eq("rst_a_busy", 128'(a_busy), 128'd0);
    check_eq("rst_a_drop", 128'(a_drop), 128'd0);
    check_eq("rst_a_trunc", 128'(a_trunc), 128'd0);
    check_eq("rst_b_valid", 128'(b_out_v), 128'd0);
    check_eq("rst_b_data", 128'(b_out_d), 128'd0);
    check_eq("rst_b_busy", 128'(b_busy), 128'd0);
    do_reset();

    // Ramp, lookback 16, trigger with input 100 -> 84..91, tlast on 91
    for (int k = 84; k <= 91; k++) push_a(k == 91, adat(k));
    for (int i = 0; i <= 110; i++) begin
      a_step(i == 100, 6'd16);
      if (i == 100) begin
        @(posedge clk); #1;
        check_eq("t1_lat_valid", 128'(a_out_v), 128'd1);
        check_eq("t1_lat_data", 128'(a_out_d), 128'(adat(84)));
        check_eq("t1_busy_in_burst", 128'(a_busy), 128'd1);
      end
    end
    end_test_a("t1");
    check_eq("t1_drops", 128'(a_drop_n), 128'd0);

    // Lookback 20 after 5 writes: 15 zeros across two bursts, then inputs 0..8
    do_reset();
    for (int k = 0; k < 8; k++) push_a(k == 7, 32'd0);
    for (int k = 0; k < 7; k++) push_a(1'b0, 32'd0);
    push_a(1'b1, adat(0));
    for (int k = 1; k <= 8; k++) push_a(k == 8, adat(k));
    for (int i = 0; i <= 28; i++) a_step(i == 5 || i == 13 || i == 21, 6'd20);
    end_test_a("t2");

    // Valid toggling, trigger on a gap cycle, lookback 0 -> bypass from next valid
    do_reset();
    for (int k = 2; k <= 9; k++) push_a(k == 9, adat(k));
    a_step(1'b0, 6'd0);
    a_gap(1'b0, 6'd0);
    a_step(1'b0, 6'd0);
    a_gap(1'b1, 6'd0);
    @(posedge clk); #1;
    check_eq("t3_busy_after_gap_trig", 128'(a_busy), 128'd1);
    check_eq("t3_no_out_on_gap", 128'(a_out_v), 128'd0);
    for (int i = 0; i < 9; i++) begin
      a_step(1'b0, 6'd0);
      a_gap(1'b0, 6'd0);
    end
    end_test_a("t3");

    // Second trigger mid-burst
    do_reset();
`ifdef SSB_CAPTURE_RETRIGGER_EN
    for (int k = 7; k <= 9; k++) push_a(1'b0, adat(k));
    for (int k = 8; k <= 15; k++) push_a(k == 15, adat(k));
`else
    for (int k = 7; k <= 14; k++) push_a(k == 14, adat(k));
`endif
    for (int i = 0; i <= 24; i++) a_step(i == 10 || i == 13, (i == 13) ? 6'd5 : 6'd3);
    end_test_a("t4");
`ifdef SSB_CAPTURE_RETRIGGER_EN
    check_eq("t4_drops", 128'(a_drop_n), 128'd0);
    check_eq("t4_truncs", 128'(a_trunc_n), 128'd1);
`else
    check_eq("t4_drops", 128'(a_drop_n), 128'd1);
    check_eq("t4_truncs", 128'(a_trunc_n), 128'd0);
`endif

    // Trigger on the final burst sample is dropped in both builds
    do_reset();
    for (int k = 2; k <= 9; k++) push_a(k == 9, adat(k));
    for (int i = 0; i <= 16; i++) a_step(i == 4 || i == 11, 6'd2);
    end_test_a("t5");
    check_eq("t5_drops", 128'(a_drop_n), 128'd1);
    check_eq("t5_truncs", 128'(a_trunc_n), 128'd0);

    // Reset mid-burst aborts without tlast; next burst sees zero-filled lookback
    do_reset();
    for (int k = 4; k <= 6; k++) push_a(1'b0, adat(k));
    for (int i = 0; i <= 7; i++) a_step(i == 5, 6'd1);
    @(negedge clk); #2;
    rst = 1'b1; a_v = 1'b0; a_t = 1'b0;
    #1;
    check_eq("t6_rst_valid", 128'(a_out_v), 128'd0);
    check_eq("t6_rst_data", 128'(a_out_d), 128'd0);
    check_eq("t6_rst_last", 128'(a_out_l), 128'd0);
    check_eq("t6_rst_busy", 128'(a_busy), 128'd0);
    check_eq("t6_pending_at_rst", 128'(exp_a_q.size()), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_idx = 0;
    for (int k = 0; k < 4; k++) push_a(1'b0, 32'd0);
    for (int k = 0; k <= 3; k++) push_a(k == 3, adat(k));
    for (int i = 0; i <= 9; i++) a_step(i == 0, 6'd4);
    end_test_a("t6");

    // Four lanes, DEPTH 8, lookback 7, CAPTURE_LEN 1 with a trigger every input
    do_reset();
    for (int i = 0; i < 22; i++) begin
      if (i >= 20) exp_b_q.push_back({1'b1, bdat(i)});
      else if (i < 7) exp_b_q.push_back({1'b1, 64'd0});
      else exp_b_q.push_back({1'b1, bdat(i - 7)});
    end
    for (int i = 0; i < 22; i++) b_step(1'b1, (i < 20) ? 3'd7 : 3'd0);
    @(negedge clk);
    b_v = 1'b0; b_t = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t7_pending", 128'(exp_b_q.size()), 128'd0);
    check_eq("t7_busy", 128'(b_busy), 128'd0);
    check_eq("t7_drops", 128'(b_drop_n), 128'd0);
    check_eq("t7_truncs", 128'(b_trunc_n), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssb_capture_buffer.md
Name: ssb_capture_buffer

Overview:
- Parametrised successor to the fixed-length sample delay line that aligns raw input samples with the late PSS peak-detect pulse ahead of FFT demodulation.
- Holds NUM_CH parallel sample streams in a circular RAM buffer.
- Lookback is runtime-programmable and latched per trigger.
- On a trigger, emits a gated burst of CAPTURE_LEN samples that starts LOOKBACK samples before the trigger, with a burst-end marker.

Parameters:
IN_DW, 32, bits per complex sample per channel (I in low half, Q in high half)
NUM_CH, 1, parallel channels sharing one valid/trigger
DEPTH, 64, buffer depth in samples (power of 2, >= 4)
CAPTURE_LEN, 1096, samples per burst (>= 1)
LB_W, $clog2(DEPTH), width of lookback control

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
s_axis_in_tdata  in  NUM_CH*IN_DW  input samples, channel c at [c*IN_DW +: IN_DW]
s_axis_in_tvalid  in  1  input sample accepted this cycle (no backpressure)
trigger_i  in  1  SSB start pulse from PSS detector
lookback_i  in  LB_W  samples to reach back before trigger (0..DEPTH-1)
m_axis_out_tdata  out  NUM_CH*IN_DW  captured delayed samples
m_axis_out_tvalid  out  1  output sample valid
m_axis_out_tlast  out  1  last sample of burst
busy_o  out  1  FSM in CAPTURE
trigger_dropped_o  out  1  one-cycle pulse, trigger not honoured
truncated_o  out  1  one-cycle pulse, burst cut short (macro only; else tied 0)

Behaviour:
- Reset: all outputs 0; FSM IDLE; write pointer, fill count, and burst count 0. RAM contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. No tlast is emitted.
- Write path: every accepted input is written at wp, then wp increments mod DEPTH. Fill count saturates at DEPTH.
- Read path: on each accepted input, read the sample accepted L inputs earlier, where L is the latched lookback.
  - L=0 returns the current input (bypass).
  - If fill count < L, that output word is all-zero instead.
- Latency: the output appears exactly 1 cycle after the accepted input. Output valid = registered (accepted input AND state CAPTURE).
- FSM states: IDLE, CAPTURE.
  - IDLE, trigger_i=1: latch L = lookback_i, cnt = 0, go to CAPTURE in the same cycle.
    - If tvalid is also 1 in that cycle, that input is burst sample 0.
    - If not, sample 0 is the next accepted input.
  - CAPTURE: each accepted input increments cnt.
    - When the accepted input has cnt = CAPTURE_LEN-1, that output carries tlast=1 and the FSM returns to IDLE.
  - CAPTURE_LEN=1: tlast on the first and only sample.
- Trigger while in CAPTURE (default build): ignored, trigger_dropped_o pulses the next cycle, lookback_i is not sampled.
- Trigger coinciding with the final accepted burst sample: always dropped, in both builds.
- lookback_i changes outside the trigger cycle have no effect on the running burst.
- lookback_i >= DEPTH cannot occur, by width.
- Widths: no arithmetic on sample data. Pointer subtraction is mod DEPTH. cnt width is $clog2(CAPTURE_LEN+1).

Optional Feature:
- Macro: SSB_CAPTURE_RETRIGGER_EN.
- Defined:
  - A trigger in CAPTURE (other than on the final sample) restarts the burst: relatch L, cnt = 0.
  - The trigger-cycle accepted input becomes sample 0 of the new burst.
  - The old burst ends without tlast; truncated_o pulses the next cycle; trigger_dropped_o stays 0.
- Undefined: default drop behaviour; truncated_o is constant 0.

Test Plan:
- Ramp input 0,1,2,... continuous valid, lookback=16, CAPTURE_LEN=8, trigger on the cycle of input 100 -> outputs 84..91 on consecutive cycles, first output 1 cycle after input 100, tlast with 91, busy_o low afterwards.
- Lookback=20, trigger when only 5 samples have been written since reset -> first 15 outputs all-zero, then inputs 0,1,... as lookback content.
- tvalid toggling 1010..., trigger on an invalid cycle, lookback=0 -> burst starts at the next valid input and outputs equal inputs with a 1-cycle delay. No output on gap cycles; cnt advances only on valid cycles.
- Second trigger mid-burst (default build) -> trigger_dropped_o single pulse, first burst completes with tlast at sample CAPTURE_LEN-1. With SSB_CAPTURE_RETRIGGER_EN -> truncated_o pulse, new burst from the trigger sample, no tlast on the old one.
- Trigger on the final burst sample -> dropped (pulse), no new burst. Reset pulse mid-burst -> all outputs 0 within the reset, next trigger after reset sees zero-filled lookback.
- NUM_CH=4, DEPTH=8, lookback=7, distinct ramps per channel -> each channel output equals its own input delayed by 7 accepted samples, no lane crossing.
